uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Serial UART receiver for the 8088 system: the receive end of the system's UART transmit line. It is used by the on-chip serial peripheral and by benches that check the system's TX output.
- Oversamples the asynchronous rx line at 16x and validates the start bit at mid-bit.
- Assembles 8N1 frames (optional parity) LSB first.
- Presents each byte through a 1-deep holding register with a valid/ready handshake and error status.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bits per second.
- OVERSAMPLE, 16: samples per bit. Fixed at 16; any other value is a compile-time error.
- PARITY_EN, 0: 1 means a parity bit follows the data bits.
- PARITY_ODD, 0: 1 means odd parity, 0 means even. Only meaningful when PARITY_EN=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx  in  1  asynchronous serial input; idles high.
- rx_data  out  8  received byte (holding register).
- rx_valid  out  1  holding register contains an unread byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid=1 and rx_ready=1.
- frame_err  out  1  stop bit of the held byte sampled low.
- parity_err  out  1  parity mismatch on the held byte. Always 0 when PARITY_EN=0.
- overrun  out  1  sticky: a completed frame was dropped because the holding register was full.
- busy  out  1  a frame is in progress (state is not IDLE).

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
  - Internals: synchronizer flops=1, state=IDLE, tick divider=0, sample counter=0, bit counter=0.
  - Reset mid-frame abandons the frame with no output update.
- Input synchronization: rx passes through a 2-flop synchronizer. All decisions use the synchronized value rxs, which lags rx by 2 clk.
- Tick generation:
  - DIV = round(CLK_HZ/(BAUD*16)); 27 at the default settings.
  - tick pulses for 1 clk every DIV clk.
  - The divider restarts at 0 on the IDLE->START transition, so the first tick lands DIV clk after the start edge is detected.
- State machine. Sample counter s runs 0..15 and advances on tick.
  - IDLE: rxs=0 -> START, s=0.
  - START: on tick with s=7:
    - rxs=0 -> DATA, s=0, bit counter=0.
    - rxs=1 -> false start, return to IDLE with no output.
  - DATA:
    - On tick with s=15, sample rxs into shift register bit position [bit counter], LSB first.
    - After bit 7: PARITY if PARITY_EN=1, else STOP.
    - Samples taken at s=15 after a mid-start alignment fall at bit centres.
  - PARITY: on tick with s=15, sample rxs and compute mismatch against the XOR of the data bits (inverted when PARITY_ODD=1). Then -> STOP.
  - STOP: on tick with s=15, sample rxs and commit the frame (see below).
    - rxs=1 -> IDLE.
    - rxs=0 -> WAIT_HIGH (line break).
  - WAIT_HIGH: remain until rxs=1, then -> IDLE. No new start is armed during a break.
- Frame commit, on the clk after the stop sample:
  - If rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle: load rx_data, frame_err and parity_err; rx_valid=1.
  - If rx_valid=1 and rx_ready=0: discard the new frame, keep the old byte and flags, set overrun=1.
- Consume:
  - rx_valid & rx_ready with no commit that cycle -> rx_valid=0 and overrun=0. rx_data and the flags hold their last values.
  - Simultaneous consume and commit: the new byte is loaded and overrun is cleared.
- Latency: rx_valid rises 2 (sync) + 1 clk after the stop-bit centre. Frame start to rx_valid is approximately 9.5 bit times (8N1).
- Frames carrying frame_err or parity_err are still delivered. Only overrun drops data.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH;
  - OVERSAMPLE=16;
  - the mid-sample index constant (7);
  - a divisor-computation function reused by the future uart_tx_core.
- One sub-module: uart_baud_tick. It is a parameterized divider with clk, rst and a sync-restart input, and a 1-clk tick output.

Test Plan:
Defaults throughout: DIV=27, bit time = 432 clk.
1. Send byte 0xA5 as 8N1 with no other activity -> rx_valid=1 about 4104 clk after the start edge; rx_data=0xA5, frame_err=0, parity_err=0, overrun=0.
2. Glitch: rx low for 100 clk, then high -> returns to IDLE, busy falls, rx_valid stays 0. Follow with 0x3C -> received correctly.
3. Hold rx_ready=0 and send 0x11 then 0x22 -> rx_data=0x11, overrun=1. Assert rx_ready for 1 clk -> rx_valid=0 and overrun=0.
4. Send 0x55 with the stop bit low and rx then held low for 2000 clk -> rx_data=0x55, frame_err=1, FSM in WAIT_HIGH. Release rx and send 0x0F -> 0x0F received with frame_err=0.
5. PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 1 -> parity_err=0. Send 0x07 with parity bit 0 -> parity_err=1.
6. Assert rst at bit 4 of a frame -> all outputs 0 on the next clk. A new 0x81 sent after release is received correctly; commit coinciding with rx_ready=1 leaves rx_valid continuously high.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: FSM state encoding, oversampling
//                constants and the baud divisor helper used by the RX and TX
//                cores.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Samples per bit; the receiver's mid-bit alignment depends on this value
    localparam int c_oversample = 16;

    // Sample index that falls at the centre of the start bit
    localparam logic [3:0] c_mid_sample  = 4'd7;

    // Last sample index of a bit period; used for data/parity/stop sampling
    localparam logic [3:0] c_last_sample = 4'd15;

    // Receiver state encoding
    typedef logic [2:0] uart_state_t;
    localparam uart_state_t c_st_idle      = 3'd0;
    localparam uart_state_t c_st_start     = 3'd1;
    localparam uart_state_t c_st_data      = 3'd2;
    localparam uart_state_t c_st_parity    = 3'd3;
    localparam uart_state_t c_st_stop      = 3'd4;
    localparam uart_state_t c_st_wait_high = 3'd5;

    // Clocks per oversample tick, rounded to nearest
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        longint denom;
        denom = longint'(baud) * longint'(os);
        return int'((longint'(clk_hz) + denom / 2) / denom);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Free-running divider producing a 1-clk tick every DIV clocks.
//                A synchronous restart realigns the divider so the first tick
//                arrives DIV clocks after the restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int              c_cw   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

    logic [c_cw-1:0] r_cnt;

    // Divider counter: wraps at DIV-1, forced to zero on restart
    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cw'(1);
        end
    end

    assign o_tick = (r_cnt == c_last) && !i_restart;

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : 16x oversampled UART receiver (8 data bits, optional parity,
//                1 stop bit) with a 1-deep holding register, valid/ready
//                handshake and frame/parity/overrun status.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    localparam int   c_div    = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam logic c_par_en = (PARITY_EN != 0);
    localparam logic c_odd    = (PARITY_ODD != 0);

    // Sample timing is built around 16 samples per bit
    if (OVERSAMPLE != c_oversample) begin : g_os_check
        $error("uart_rx_core: OVERSAMPLE must be 16");
    end

    logic        r_rx_meta;
    logic        r_rxs;
    uart_state_t r_state;
    uart_state_t w_state_nxt;
    logic [3:0]  r_samp;
    logic [3:0]  w_samp_nxt;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic        r_stop_bad;
    logic        r_par_bad;
    logic        r_commit;
    logic        w_tick;
    logic        w_restart;
    logic        w_take_data;
    logic        w_take_par;
    logic        w_take_stop;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // Realign the tick divider to the detected start edge
    assign w_restart = (r_state == c_st_idle) && !r_rxs;

    uart_baud_tick #(
        .DIV (c_div)
    ) u_baud_tick (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    // Next-state, sample/bit counter and sampling strobes
    always_comb begin
        w_state_nxt = r_state;
        w_samp_nxt  = r_samp;
        w_bit_nxt   = r_bit;
        w_take_data = 1'b0;
        w_take_par  = 1'b0;
        w_take_stop = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!r_rxs) begin
                    w_state_nxt = c_st_start;
                    w_samp_nxt  = 4'd0;
                end
            end
            c_st_start: begin
                if (w_tick) begin
                    if (r_samp == c_mid_sample) begin
                        w_samp_nxt  = 4'd0;
                        w_bit_nxt   = 3'd0;
                        // A start bit that is no longer low at mid-bit was a glitch
                        w_state_nxt = r_rxs ? c_st_idle : c_st_data;
                    end else begin
                        w_samp_nxt = r_samp + 4'd1;
                    end
                end
            end
            c_st_data: begin
                if (w_tick) begin
                    w_samp_nxt = r_samp + 4'd1;
                    if (r_samp == c_last_sample) begin
                        w_take_data = 1'b1;
                        w_bit_nxt   = r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            w_state_nxt = c_par_en ? c_st_parity : c_st_stop;
                        end
                    end
                end
            end
            c_st_parity: begin
                if (w_tick) begin
                    w_samp_nxt = r_samp + 4'd1;
                    if (r_samp == c_last_sample) begin
                        w_take_par  = 1'b1;
                        w_state_nxt = c_st_stop;
                    end
                end
            end
            c_st_stop: begin
                if (w_tick) begin
                    w_samp_nxt = r_samp + 4'd1;
                    if (r_samp == c_last_sample) begin
                        w_take_stop = 1'b1;
                        // A low stop bit means a break; wait for the line to recover
                        w_state_nxt = r_rxs ? c_st_idle : c_st_wait_high;
                    end
                end
            end
            c_st_wait_high: begin
                if (r_rxs) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_samp  <= 4'd0;
            r_bit   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_samp  <= w_samp_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    // Frame assembly: data bits LSB first, parity check, stop check, commit strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= 8'd0;
            r_stop_bad <= 1'b0;
            r_par_bad  <= 1'b0;
            r_commit   <= 1'b0;
        end else begin
            if (w_take_data) begin
                r_shift[r_bit] <= r_rxs;
            end
            if (w_take_par) begin
                r_par_bad <= r_rxs ^ (^r_shift) ^ c_odd;
            end
            if (w_take_stop) begin
                r_stop_bad <= !r_rxs;
            end
            r_commit <= w_take_stop;
        end
    end

    // Holding register with valid/ready handshake and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else if (r_commit) begin
            if (!rx_valid || rx_ready) begin
                rx_data    <= r_shift;
                frame_err  <= r_stop_bad;
                parity_err <= c_par_en && r_par_bad;
                rx_valid   <= 1'b1;
                overrun    <= 1'b0;
            end else begin
                overrun    <= 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

    assign busy = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_core
//  Description : Directed self-checking bench for uart_rx_core at default
//                rates (DIV=27, 432 clk per bit), plus a parity-enabled copy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int c_bit_clk = 432;
    localparam int c_lat_nom = 4108;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       rx         = 1'b1;
    logic       rx_ready   = 1'b0;
    logic       rx_p       = 1'b1;
    logic       rx_ready_p = 1'b0;

    logic [7:0] w_rx_data;
    logic       w_rx_valid;
    logic       w_frame_err;
    logic       w_parity_err;
    logic       w_overrun;
    logic       w_busy;

    logic [7:0] w_rx_data_p;
    logic       w_rx_valid_p;
    logic       w_frame_err_p;
    logic       w_parity_err_p;
    logic       w_overrun_p;
    logic       w_busy_p;

    int cyc        = 0;
    int n_checks   = 0;
    int n_errors   = 0;
    int r_t0       = 0;
    int r_rise_cyc = -1;
    int r_drop_cnt = 0;
    int lat        = c_lat_nom;
    logic r_prev_valid = 1'b0;
    logic r_mon        = 1'b0;

    uart_rx_core dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (w_rx_data),
        .rx_valid   (w_rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (w_frame_err),
        .parity_err (w_parity_err),
        .overrun    (w_overrun),
        .busy       (w_busy)
    );

    uart_rx_core #(
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut_p (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_p),
        .rx_data    (w_rx_data_p),
        .rx_valid   (w_rx_valid_p),
        .rx_ready   (rx_ready_p),
        .frame_err  (w_frame_err_p),
        .parity_err (w_parity_err_p),
        .overrun    (w_overrun_p),
        .busy       (w_busy_p)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record when rx_valid rises and count cycles where it is low while monitored
    always @(negedge clk) begin
        if (w_rx_valid && !r_prev_valid) r_rise_cyc = cyc;
        r_prev_valid = w_rx_valid;
        if (r_mon && !w_rx_valid) r_drop_cnt = r_drop_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit to_p, input logic b);
        if (to_p) rx_p = b;
        else      rx   = b;
    endtask

    // Serial frame: start, 8 data LSB first, optional parity, stop
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input bit par_en, input logic par_bit, input bit to_p);
        logic [10:0] bits;
        int nb;
        bits = '0;
        bits[8:1] = data;
        if (par_en) begin
            bits[9]  = par_bit;
            bits[10] = stop_bit;
            nb = 11;
        end else begin
            bits[9] = stop_bit;
            nb = 10;
        end
        r_t0 = cyc;
        for (int i = 0; i < nb; i++) begin
            drive(to_p, bits[i]);
            repeat (c_bit_clk) @(negedge clk);
        end
    endtask

    task automatic consume(input bit to_p);
        if (to_p) rx_ready_p = 1'b1;
        else      rx_ready   = 1'b1;
        @(negedge clk);
        rx_ready   = 1'b0;
        rx_ready_p = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid",   w_rx_valid,   0);
        check("rst_data",    w_rx_data,    0);
        check("rst_ferr",    w_frame_err,  0);
        check("rst_perr",    w_parity_err, 0);
        check("rst_overrun", w_overrun,    0);
        check("rst_busy",    w_busy,       0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1. Plain 8N1 byte
        send_frame(8'hA5, 1'b1, 0, 1'b0, 0);
        lat = r_rise_cyc - r_t0;
        check("t1_latency_ok", (lat >= 4100 && lat <= 4116), 1);
        if (lat < 4100 || lat > 4116) lat = c_lat_nom;
        check("t1_valid",   w_rx_valid,   1);
        check("t1_data",    w_rx_data,    8'hA5);
        check("t1_ferr",    w_frame_err,  0);
        check("t1_perr",    w_parity_err, 0);
        check("t1_overrun", w_overrun,    0);
        check("t1_busy",    w_busy,       0);
        consume(0);
        check("t1_consumed", w_rx_valid, 0);

        // 2. Glitch shorter than half a bit, then a real byte
        rx = 1'b0;
        repeat (50) @(negedge clk);
        check("t2_busy_glitch", w_busy, 1);
        repeat (50) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        check("t2_busy_after", w_busy,     0);
        check("t2_no_valid",   w_rx_valid, 0);
        send_frame(8'h3C, 1'b1, 0, 1'b0, 0);
        check("t2_valid", w_rx_valid, 1);
        check("t2_data",  w_rx_data,  8'h3C);
        consume(0);

        // 3. Overrun with consumer stalled
        send_frame(8'h11, 1'b1, 0, 1'b0, 0);
        send_frame(8'h22, 1'b1, 0, 1'b0, 0);
        check("t3_valid",   w_rx_valid, 1);
        check("t3_data",    w_rx_data,  8'h11);
        check("t3_overrun", w_overrun,  1);
        consume(0);
        check("t3_valid_clr",   w_rx_valid, 0);
        check("t3_overrun_clr", w_overrun,  0);

        // 4. Low stop bit followed by a line break
        send_frame(8'h55, 1'b0, 0, 1'b0, 0);
        repeat (2000) @(negedge clk);
        check("t4_valid", w_rx_valid,  1);
        check("t4_data",  w_rx_data,   8'h55);
        check("t4_ferr",  w_frame_err, 1);
        check("t4_busy_break", w_busy, 1);
        consume(0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("t4_busy_released", w_busy, 0);
        send_frame(8'h0F, 1'b1, 0, 1'b0, 0);
        check("t4b_valid", w_rx_valid,  1);
        check("t4b_data",  w_rx_data,   8'h0F);
        check("t4b_ferr",  w_frame_err, 0);

        // 5. Even parity on the parity-enabled instance
        send_frame(8'h07, 1'b1, 1, 1'b1, 1);
        check("t5_valid", w_rx_valid_p,   1);
        check("t5_data",  w_rx_data_p,    8'h07);
        check("t5_perr",  w_parity_err_p, 0);
        check("t5_ferr",  w_frame_err_p,  0);
        consume(1);
        send_frame(8'h07, 1'b1, 1, 1'b0, 1);
        check("t5b_valid", w_rx_valid_p,   1);
        check("t5b_data",  w_rx_data_p,    8'h07);
        check("t5b_perr",  w_parity_err_p, 1);
        consume(1);

        // 6. Reset during bit 4 of a frame (0x0F still held)
        rx = 1'b0;
        repeat (c_bit_clk) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0);
            repeat (c_bit_clk) @(negedge clk);
        end
        rx = 1'b0;
        repeat (200) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check("t6_rst_valid",   w_rx_valid,   0);
        check("t6_rst_data",    w_rx_data,    0);
        check("t6_rst_ferr",    w_frame_err,  0);
        check("t6_rst_perr",    w_parity_err, 0);
        check("t6_rst_overrun", w_overrun,    0);
        check("t6_rst_busy",    w_busy,       0);
        rst = 1'b0;
        repeat (500) @(negedge clk);
        check("t6_idle_busy",  w_busy,     0);
        check("t6_idle_valid", w_rx_valid, 0);
        send_frame(8'h81, 1'b1, 0, 1'b0, 0);
        check("t6_valid", w_rx_valid, 1);
        check("t6_data",  w_rx_data,  8'h81);
        send_frame(8'h18, 1'b1, 0, 1'b0, 0);
        check("t6_ovr_set",  w_overrun, 1);
        check("t6_ovr_data", w_rx_data, 8'h81);
        // Consume exactly on the commit cycle of the next byte
        r_drop_cnt = 0;
        r_mon      = 1'b1;
        fork
            send_frame(8'h42, 1'b1, 0, 1'b0, 0);
            begin
                repeat (lat - 1) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        r_mon = 1'b0;
        check("t6_valid_never_low", r_drop_cnt, 0);
        check("t6_same_cycle_data", w_rx_data,  8'h42);
        check("t6_same_cycle_ovr",  w_overrun,  0);
        consume(0);
        check("t6_final_valid", w_rx_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
